// File: rtl/card_deal_ctrl_if.sv
// Hand-memory write port of the card dealer: request/ready handshake plus
// player, slot and card fields.
interface card_deal_ctrl_if #(
   parameter int SLOT_W = 2,
   parameter int CARD_W = 4
) ();
   logic              WR_EN;
   logic              WR_READY;
   logic              WR_PLAYER;
   logic [SLOT_W-1:0] WR_SLOT;
   logic [CARD_W-1:0] WR_CARD;

   modport master (
      output WR_EN,
      output WR_PLAYER,
      output WR_SLOT,
      output WR_CARD,
      input  WR_READY
   );

   modport slave (
      input  WR_EN,
      input  WR_PLAYER,
      input  WR_SLOT,
      input  WR_CARD,
      output WR_READY
   );
endinterface

// File: rtl/card_deal_ctrl.sv
// Big 2 card dealer: shuffles with an 8-bit LFSR and writes P1/P2 hands alternately.
// Optional macro FIXED_DEAL_EN swaps the LFSR for a wrapping up-counter (ordered deal).
module card_deal_ctrl #(
   parameter int DECK_SIZE = 16,
   parameter int HAND_SIZE = 4,
   parameter int CARD_W    = 4,
   parameter int SLOT_W    = 2
) (
   input  logic                clka,
   input  logic                RESTART,
   input  logic                CARD_GEN,
   input  logic [7:0]          SEED,
   card_deal_ctrl_if.master    wr,
   output logic                CARD_DONE,
   output logic                BUSY
);

   localparam int CNT_W = $clog2(2*HAND_SIZE + 1);
   localparam logic [CARD_W:0] DECK_LIM = (CARD_W+1)'(DECK_SIZE);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2*HAND_SIZE - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_DRAW  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [2**CARD_W-1:0]  dealt_q, dealt_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  wr_en_q, wr_en_d;
   logic                  wr_player_q, wr_player_d;
   logic [SLOT_W-1:0]     wr_slot_q, wr_slot_d;
   logic [CARD_W-1:0]     wr_card_q, wr_card_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic [CARD_W-1:0]     cand;
   logic                  cand_ok;

`ifdef FIXED_DEAL_EN
   logic [CARD_W-1:0] ctr_q, ctr_d;
   assign cand = ctr_q;
`else
   logic [7:0] lfsr_q, lfsr_d;
   assign cand = lfsr_q[CARD_W-1:0];
`endif

   // Bitmap is sized to the full ID space so any candidate indexes it safely.
   assign cand_ok = ({1'b0, cand} < DECK_LIM) && !dealt_q[cand];

   always_comb begin
      state_d     = state_q;
      dealt_d     = dealt_q;
      cnt_d       = cnt_q;
      wr_en_d     = wr_en_q;
      wr_player_d = wr_player_q;
      wr_slot_d   = wr_slot_q;
      wr_card_d   = wr_card_q;
`ifdef FIXED_DEAL_EN
      ctr_d       = ctr_q;
`else
      lfsr_d      = lfsr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (CARD_GEN) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (!CARD_GEN) begin
               state_d = S_IDLE;
            end else begin
`ifdef FIXED_DEAL_EN
               ctr_d   = SEED[CARD_W-1:0];
`else
               lfsr_d  = (SEED == 8'h00) ? 8'hA5 : SEED;
`endif
               dealt_d = '0;
               cnt_d   = '0;
               state_d = S_DRAW;
            end
         end
         S_DRAW: begin
            if (!CARD_GEN) begin
               state_d = S_IDLE;
            end else begin
`ifdef FIXED_DEAL_EN
               ctr_d = (ctr_q == CARD_W'(DECK_SIZE - 1)) ? '0 : ctr_q + 1'b1;
`else
               lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
               if (cand_ok) begin
                  wr_card_d   = cand;
                  wr_player_d = cnt_q[0];
                  wr_slot_d   = SLOT_W'(cnt_q >> 1);
                  wr_en_d     = 1'b1;
                  state_d     = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            // Abort takes priority over a handshake completing in the same cycle.
            if (!CARD_GEN) begin
               wr_en_d = 1'b0;
               state_d = S_IDLE;
            end else if (wr.WR_READY) begin
               dealt_d[wr_card_q] = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               wr_en_d = 1'b0;
               state_d = (cnt_q == LAST_CNT) ? S_DONE : S_DRAW;
            end
         end
         S_DONE: begin
            if (!CARD_GEN) state_d = S_IDLE;
         end
         default: begin
            wr_en_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
      done_d = (state_d == S_DONE);
      busy_d = (state_d == S_LOAD) || (state_d == S_DRAW) || (state_d == S_WRITE);
   end

   always_ff @(posedge clka) begin
      if (RESTART) begin
         state_q     <= S_IDLE;
         dealt_q     <= '0;
         cnt_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_player_q <= 1'b0;
         wr_slot_q   <= '0;
         wr_card_q   <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
`ifdef FIXED_DEAL_EN
         ctr_q       <= '0;
`else
         lfsr_q      <= 8'h01;
`endif
      end else begin
         state_q     <= state_d;
         dealt_q     <= dealt_d;
         cnt_q       <= cnt_d;
         wr_en_q     <= wr_en_d;
         wr_player_q <= wr_player_d;
         wr_slot_q   <= wr_slot_d;
         wr_card_q   <= wr_card_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
`ifdef FIXED_DEAL_EN
         ctr_q       <= ctr_d;
`else
         lfsr_q      <= lfsr_d;
`endif
      end
   end

   assign wr.WR_EN     = wr_en_q;
   assign wr.WR_PLAYER = wr_player_q;
   assign wr.WR_SLOT   = wr_slot_q;
   assign wr.WR_CARD   = wr_card_q;
   assign CARD_DONE    = done_q;
   assign BUSY         = busy_q;

endmodule

// File: tb/tb_card_deal_ctrl.sv
// Self-checking bench for card_deal_ctrl: 16-card and 13-card dealers share stimulus;
// a reference shuffle model fills write scoreboards and predicts deal latency.
module tb_card_deal_ctrl;

   logic       clka = 1'b0;
   logic       RESTART = 1'b1;
   logic       CARD_GEN = 1'b0;
   logic [7:0] SEED = 8'h00;
   logic       done1, busy1, done2, busy2;

   card_deal_ctrl_if #(.SLOT_W(2), .CARD_W(4)) w1 ();
   card_deal_ctrl_if #(.SLOT_W(2), .CARD_W(4)) w2 ();

   card_deal_ctrl #(.DECK_SIZE(16), .HAND_SIZE(4), .CARD_W(4), .SLOT_W(2)) dut1 (
      .clka(clka), .RESTART(RESTART), .CARD_GEN(CARD_GEN), .SEED(SEED),
      .wr(w1), .CARD_DONE(done1), .BUSY(busy1));

   card_deal_ctrl #(.DECK_SIZE(13), .HAND_SIZE(4), .CARD_W(4), .SLOT_W(2)) dut2 (
      .clka(clka), .RESTART(RESTART), .CARD_GEN(CARD_GEN), .SEED(SEED),
      .wr(w2), .CARD_DONE(done2), .BUSY(busy2));

   always #5 clka = ~clka;

   typedef logic [3:0] card_arr_t [0:7];
   typedef struct {logic player; logic [1:0] slot; logic [3:0] card;} wr_t;
   typedef struct {logic [7:0] seed; int stall_at; int stall_len; int exp_done;} vec_t;

   wr_t q1[$];
   wr_t q2[$];
   int  n_cmp = 0;
   int  n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference shuffle: returns total DRAW cycles spent for the 8 cards.
   function automatic int model(input logic [7:0] seed, input int deck, output card_arr_t cards);
      logic [7:0]  l;
      logic [15:0] used;
      logic [3:0]  c;
      int          draws;
      int          k;
      draws = 0;
      used  = '0;
      k     = 0;
`ifdef FIXED_DEAL_EN
      l = {4'h0, seed[3:0]};
`else
      l = (seed == 8'h00) ? 8'hA5 : seed;
`endif
      while (k < 8 && draws < 10000) begin
         c = l[3:0];
         draws++;
`ifdef FIXED_DEAL_EN
         l = (int'(l) == deck - 1) ? 8'h00 : {4'h0, 4'(l[3:0] + 4'd1)};
`else
         l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
`endif
         if (int'(c) < deck && !used[c]) begin
            used[c]  = 1'b1;
            cards[k] = c;
            k++;
         end
      end
      return draws;
   endfunction

   task automatic fill_q(input int deck, input card_arr_t m, output int draws_unused);
      wr_t e;
      draws_unused = 0;
      for (int k = 0; k < 8; k++) begin
         e.player = 1'(k % 2);
         e.slot   = 2'(k / 2);
         e.card   = m[k];
         if (deck == 16) q1.push_back(e);
         else            q2.push_back(e);
      end
   endtask

   task automatic run_deal(input logic [7:0] seed, input int stall_at, input int stall_len,
                           input int exp_done1, output card_arr_t seen);
      card_arr_t   m1, m2;
      int          d2, t, t1, t2, widx1, stalled, dummy;
      logic [15:0] bm2;
      wr_t         e;
      q1.delete();
      q2.delete();
      void'(model(seed, 16, m1));
      d2 = model(seed, 13, m2);
      fill_q(16, m1, dummy);
      fill_q(13, m2, dummy);
      seen = '{default: 4'h0};
      @(negedge clka);
      SEED     = seed;
      CARD_GEN = 1'b1;
      @(negedge clka);
      t = 0; t1 = -1; t2 = -1; widx1 = 0; stalled = 0; bm2 = '0;
      chk("busy_in_load", int'(busy1), 1);
      while ((t1 < 0 || t2 < 0) && t < 3000) begin
         if (t1 < 0 && done1) begin
            t1 = t;
            chk("done_cycle", t, exp_done1);
            chk("busy_at_done", int'(busy1), 0);
         end
         if (w1.WR_EN) begin
            if (widx1 == stall_at && stalled < stall_len) begin
               w1.WR_READY = 1'b0;
               stalled++;
               if (q1.size() > 0) begin
                  chk("stall_card", int'(w1.WR_CARD), int'(q1[0].card));
                  chk("stall_slot", int'(w1.WR_SLOT), int'(q1[0].slot));
                  chk("stall_player", int'(w1.WR_PLAYER), int'(q1[0].player));
               end
            end else begin
               w1.WR_READY = 1'b1;
               if (q1.size() == 0) begin
                  chk("extra_write1", 1, 0);
               end else begin
                  e = q1.pop_front();
                  chk("wr_card", int'(w1.WR_CARD), int'(e.card));
                  chk("wr_slot", int'(w1.WR_SLOT), int'(e.slot));
                  chk("wr_player", int'(w1.WR_PLAYER), int'(e.player));
                  if (widx1 < 8) seen[widx1] = w1.WR_CARD;
               end
               widx1++;
            end
         end else begin
            w1.WR_READY = 1'($urandom_range(0, 1));
         end
         w2.WR_READY = 1'b1;
         if (w2.WR_EN) begin
            chk("deck13_range", int'(w2.WR_CARD < 4'd13), 1);
            chk("deck13_distinct", int'(bm2[w2.WR_CARD]), 0);
            bm2[w2.WR_CARD] = 1'b1;
            if (q2.size() == 0) begin
               chk("extra_write2", 1, 0);
            end else begin
               e = q2.pop_front();
               chk("deck13_card", int'(w2.WR_CARD), int'(e.card));
            end
         end
         if (t2 < 0 && done2) begin
            t2 = t;
            chk("deck13_done_cycle", t, 1 + d2 + 8);
         end
         @(negedge clka);
         t++;
      end
      if (t1 < 0) chk("timeout_dut1", 0, 1);
      if (t2 < 0) chk("timeout_dut2", 0, 1);
      chk("q1_empty", q1.size(), 0);
      chk("q2_empty", q2.size(), 0);
      chk("done_held", int'(done1), 1);
      CARD_GEN = 1'b0;
      @(negedge clka);
      chk("done_cleared", int'(done1), 0);
      chk("busy_idle", int'(busy1), 0);
      chk("done2_cleared", int'(done2), 0);
      w1.WR_READY = 1'b1;
   endtask

   task automatic abort_deal(input logic [7:0] seed, input bit use_restart);
      card_arr_t m1;
      int        t, widx, dummy;
      bit        aborted;
      wr_t       e;
      q1.delete();
      void'(model(seed, 16, m1));
      fill_q(16, m1, dummy);
      q2.delete();
      w1.WR_READY = 1'b1;
      w2.WR_READY = 1'b1;
      @(negedge clka);
      SEED     = seed;
      CARD_GEN = 1'b1;
      t = 0; widx = 0; aborted = 1'b0;
      while (!aborted && t < 1000) begin
         @(negedge clka);
         t++;
         if (w1.WR_EN) begin
            if (widx == 4) begin
               if (use_restart) RESTART = 1'b1;
               else             CARD_GEN = 1'b0;
               @(negedge clka);
               chk("abort_wr_en", int'(w1.WR_EN), 0);
               chk("abort_busy", int'(busy1), 0);
               chk("abort_done", int'(done1), 0);
               if (use_restart) begin
                  chk("restart_card", int'(w1.WR_CARD), 0);
                  chk("restart_slot", int'(w1.WR_SLOT), 0);
               end
               aborted = 1'b1;
            end else begin
               e = q1.pop_front();
               chk("pre_abort_card", int'(w1.WR_CARD), int'(e.card));
               widx++;
            end
         end
      end
      if (!aborted) chk("abort_timeout", 0, 1);
      RESTART  = 1'b0;
      CARD_GEN = 1'b0;
      @(negedge clka);
      chk("post_abort_busy", int'(busy1), 0);
      chk("post_abort_done", int'(done1), 0);
   endtask

   vec_t      vecs [0:5];
   card_arr_t m, s0, s_a5, sx;
   int        d;

   initial begin
      w1.WR_READY = 1'b1;
      w2.WR_READY = 1'b1;
      vecs[0] = '{seed: 8'h3C, stall_at: -1, stall_len: 0, exp_done: 0};
      vecs[1] = '{seed: 8'h00, stall_at: -1, stall_len: 0, exp_done: 0};
      vecs[2] = '{seed: 8'hA5, stall_at: -1, stall_len: 0, exp_done: 0};
      vecs[3] = '{seed: 8'h5A, stall_at: 2,  stall_len: 5, exp_done: 0};
      vecs[4] = '{seed: 8'hFF, stall_at: 7,  stall_len: 2, exp_done: 0};
      vecs[5] = '{seed: 8'h01, stall_at: 0,  stall_len: 1, exp_done: 0};
      for (int i = 0; i < 6; i++) begin
         d = model(vecs[i].seed, 16, m);
         vecs[i].exp_done = 1 + d + 8 + vecs[i].stall_len;
      end

      repeat (3) @(posedge clka);
      @(negedge clka);
      chk("rst_wr_en", int'(w1.WR_EN), 0);
      chk("rst_player", int'(w1.WR_PLAYER), 0);
      chk("rst_slot", int'(w1.WR_SLOT), 0);
      chk("rst_card", int'(w1.WR_CARD), 0);
      chk("rst_done", int'(done1), 0);
      chk("rst_busy", int'(busy1), 0);
      RESTART = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_deal(vecs[i].seed, vecs[i].stall_at, vecs[i].stall_len, vecs[i].exp_done, sx);
         if (vecs[i].seed == 8'h00) s0 = sx;
         if (vecs[i].seed == 8'hA5) s_a5 = sx;
      end
`ifdef FIXED_DEAL_EN
      for (int k = 0; k < 8; k++) chk("fixed_order", int'(s0[k]), k);
      chk("fixed_latency", vecs[1].exp_done, 17);
`else
      for (int k = 0; k < 8; k++) chk("seed0_eq_a5", int'(s0[k]), int'(s_a5[k]));
`endif

      for (int i = 0; i < 10; i++) begin
         logic [7:0] rs;
         rs = 8'($urandom_range(0, 255));
         d = model(rs, 16, m);
         run_deal(rs, -1, 0, 1 + d + 8, sx);
      end

      abort_deal(8'h3C, 1'b1);
      run_deal(8'h3C, -1, 0, vecs[0].exp_done, sx);
      abort_deal(8'h77, 1'b0);
      run_deal(8'h3C, 2, 5, vecs[0].exp_done + 5, sx);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/card_deal_ctrl.md
Name: card_deal_ctrl

Overview:
- Sequences the card-generation/distribution phase of the Big 2 datapath: shuffles a deck with an LFSR and writes each player's hand memory, alternating P1/P2.
- Started by the game FSM's CARD_GEN level; answers with CARD_DONE, which moves the game FSM from CARD_WAIT to P1.
- Owns the write port of both hand memories during dealing.

Parameters:
- DECK_SIZE, 16, number of distinct cards; IDs 0..DECK_SIZE-1; DECK_SIZE <= 2**CARD_W.
- HAND_SIZE, 4, cards dealt per player; 2*HAND_SIZE <= DECK_SIZE.
- CARD_W, 4, card ID width; 1..8.
- SLOT_W, 2, hand slot index width; 2**SLOT_W >= HAND_SIZE.

Ports:
- clka  in  1  clock, all logic on posedge.
- RESTART  in  1  synchronous active-high reset.
- CARD_GEN  in  1  level request from game FSM; high = deal.
- SEED  in  8  LFSR seed, sampled in LOAD.
- WR_READY  in  1  hand memory accepts the current write.
- WR_EN  out  1  write request, registered.
- WR_PLAYER  out  1  0 = P1, 1 = P2.
- WR_SLOT  out  SLOT_W  slot within that hand.
- WR_CARD  out  CARD_W  card ID.
- CARD_DONE  out  1  deal complete, registered.
- BUSY  out  1  high in LOAD/DRAW/WRITE.

Behaviour:
- Reset (RESTART high at a posedge): state IDLE, lfsr=8'h01, dealt bitmap=0, cnt=0.
- Reset outputs: WR_EN=0, WR_PLAYER=0, WR_SLOT=0, WR_CARD=0, CARD_DONE=0, BUSY=0.
- RESTART overrides everything, including mid-deal; any handshake pending in that cycle is discarded.
- LFSR: 8-bit Fibonacci, lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}, maximal period 255.
- Candidate card = lfsr[CARD_W-1:0].
- IDLE -> LOAD when CARD_GEN=1.
- LOAD (1 cycle):
  - lfsr <= (SEED==0) ? 8'hA5 : SEED.
  - dealt <= 0, cnt <= 0.
  - -> DRAW.
- DRAW (one candidate per cycle; lfsr advances every DRAW cycle):
  - Reject if candidate >= DECK_SIZE or dealt[candidate]=1; stay in DRAW.
  - Otherwise latch WR_CARD=candidate, WR_PLAYER=cnt[0], WR_SLOT=cnt>>1; -> WRITE.
  - Termination is guaranteed: every low-nibble value recurs within 255 steps.
- WRITE:
  - WR_EN=1; WR_CARD/WR_PLAYER/WR_SLOT stable; lfsr holds.
  - On WR_EN & WR_READY:
    - dealt[WR_CARD] <= 1, cnt <= cnt+1, WR_EN <= 0.
    - If cnt == 2*HAND_SIZE-1 -> DONE, else -> DRAW.
  - WR_READY low: stall indefinitely.
- DONE:
  - CARD_DONE=1, BUSY=0.
  - Holds until CARD_GEN=0, then -> IDLE with CARD_DONE=0 on that edge.
- Abort: CARD_GEN=0 while in LOAD/DRAW/WRITE -> IDLE at that edge.
  - Abort wins over a same-cycle handshake; that write is not counted, and the hand contents are invalid.
  - CARD_DONE is never asserted for an aborted deal.
- Deal order: P1 slot0, P2 slot0, P1 slot1, P2 slot1, and so on.
- All 2*HAND_SIZE cards are distinct and < DECK_SIZE.
- Minimum latency per card: 2 cycles (1 DRAW + 1 WRITE with WR_READY=1).
- Minimum total: 1 + 2*2*HAND_SIZE cycles from LOAD to DONE.
- CARD_GEN high again in IDLE after a completed deal starts a fresh deal.

Optional Feature:
- Macro FIXED_DEAL_EN.
- Defined:
  - The LFSR is replaced by a CARD_W-bit up-counter loaded with SEED[CARD_W-1:0] in LOAD, wrapping at DECK_SIZE-1 -> 0.
  - Rejection rules are unchanged, giving a deterministic ordered deal for bring-up.
- Undefined: LFSR shuffle as above; no counter logic is present.

Test Plan:
- FIXED_DEAL_EN, SEED=0, WR_READY=1, CARD_GEN held high -> writes (P1,0,0)(P2,0,1)(P1,1,2)(P2,1,3)(P1,2,4)(P2,2,5)(P1,3,6)(P2,3,7); CARD_DONE high 17 cycles after LOAD; drop CARD_GEN -> CARD_DONE=0 next edge.
- LFSR mode, SEED=8'h3C, WR_READY=1 -> 8 writes; all WR_CARD distinct and <16; slots/players in the order above; CARD_DONE=1 then IDLE after CARD_GEN=0.
- SEED=0 vs SEED=8'hA5 -> identical WR_CARD sequences.
- WR_READY held low for 5 cycles during the 3rd write -> WR_EN stays 1 with WR_CARD/WR_SLOT/WR_PLAYER unchanged; cnt does not advance; deal resumes on WR_READY=1.
- DECK_SIZE=13, 10 random seeds -> no WR_CARD >= 13; all cards distinct.
- RESTART (or CARD_GEN=0) asserted during the 5th write with WR_READY=1 -> next edge WR_EN=0, BUSY=0, CARD_DONE=0, state IDLE; a new CARD_GEN deal starts again from P1 slot0.
